// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable wait states
module dmem_responder #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_be,
   output logic        o_busy,
   output logic        o_rvalid,
   output logic [31:0] o_rdata,
   output logic        o_wack,
   output logic        o_err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam int         DEPTH     = 1 << ADDR_W;
   // Counter preload; unused when there are no wait states.
   localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   state_t              state, state_nxt;
   logic [3:0]          cnt, cnt_nxt;

   // Request fields captured at acceptance, used when the access happens after WAIT.
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_idx;
   logic [31:0]         lat_wdata;
   logic [3:0]          lat_be;

   logic [31:0]         mem [DEPTH];

   logic                accept;
   logic                bad_addr;
   logic                acc_en;
   logic                acc_we;
   logic [ADDR_W-1:0]   acc_idx;
   logic [31:0]         acc_wdata;
   logic [3:0]          acc_be;
   logic                rvalid_nxt;
   logic                wack_nxt;
   logic                err_nxt;

   assign accept   = (state != S_WAIT) && i_req;
   assign bad_addr = (i_addr[1:0] != 2'b00) || ((i_addr >> (ADDR_W + 2)) != 32'd0);
   assign o_busy   = accept || (state == S_WAIT);

   // Next state, wait counter, and the array access that happens on the edge entering RESP.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      acc_en     = 1'b0;
      acc_we     = lat_we;
      acc_idx    = lat_idx;
      acc_wdata  = lat_wdata;
      acc_be     = lat_be;
      rvalid_nxt = 1'b0;
      wack_nxt   = 1'b0;
      err_nxt    = 1'b0;
      case (state)
         S_IDLE, S_RESP: begin
            if (i_req) begin
               if (bad_addr) begin
                  state_nxt = S_RESP;
                  err_nxt   = 1'b1;
               end else if (WAIT_STATES == 0) begin
                  state_nxt = S_RESP;
                  acc_en    = 1'b1;
                  acc_we    = i_we;
                  acc_idx   = i_addr[ADDR_W+1:2];
                  acc_wdata = i_wdata;
                  acc_be    = i_be;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = WAIT_INIT;
               end
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt = S_RESP;
               acc_en    = 1'b1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (acc_en) begin
         rvalid_nxt = !acc_we;
         wack_nxt   = acc_we;
      end
   end

   // State register, counter, response pulses and load data.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         o_rvalid <= 1'b0;
         o_wack   <= 1'b0;
         o_err    <= 1'b0;
         o_rdata  <= 32'd0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         o_rvalid <= rvalid_nxt;
         o_wack   <= wack_nxt;
         o_err    <= err_nxt;
         if (acc_en && !acc_we) begin
            o_rdata <= mem[acc_idx];
         end
      end
   end

   // Capture the request so the requester-held inputs are not relied on after acceptance.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         lat_we    <= i_we;
         lat_idx   <= i_addr[ADDR_W+1:2];
         lat_wdata <= i_wdata;
         lat_be    <= i_be;
      end
   end

   // Byte-enabled array write; a reset on the commit edge cancels the store.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && acc_en && acc_we) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_be[b]) begin
               mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

   typedef struct {
      int          k;
      int          cyc;
      int          kind;   // 0 load, 1 store ack, 2 error
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n [3];
   logic        req   [3];
   logic        we    [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [3:0]  be    [3];
   logic        busy  [3];
   logic        rvalid[3];
   logic [31:0] rdata [3];
   logic        wack  [3];
   logic        err   [3];

   int          ws [3] = '{2, 0, 15};
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          pend_until [3];
   int          seen_rv_cyc [3];
   logic [31:0] last_rd [3];
   logic [31:0] mem_m [3][256];
   exp_t        expq[$];
   exp_t        keep[$];

   dmem_responder #(.ADDR_W(8), .WAIT_STATES(2)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n[0]), .i_req(req[0]), .i_we(we[0]), .i_addr(addr[0]),
      .i_wdata(wdata[0]), .i_be(be[0]), .o_busy(busy[0]), .o_rvalid(rvalid[0]),
      .o_rdata(rdata[0]), .o_wack(wack[0]), .o_err(err[0]));
   dmem_responder #(.ADDR_W(8), .WAIT_STATES(0)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n[1]), .i_req(req[1]), .i_we(we[1]), .i_addr(addr[1]),
      .i_wdata(wdata[1]), .i_be(be[1]), .o_busy(busy[1]), .o_rvalid(rvalid[1]),
      .o_rdata(rdata[1]), .o_wack(wack[1]), .o_err(err[1]));
   dmem_responder #(.ADDR_W(8), .WAIT_STATES(15)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n[2]), .i_req(req[2]), .i_we(we[2]), .i_addr(addr[2]),
      .i_wdata(wdata[2]), .i_be(be[2]), .o_busy(busy[2]), .o_rvalid(rvalid[2]),
      .o_rdata(rdata[2]), .o_wack(wack[2]), .o_err(err[2]));

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle index: cycle c is the interval following rising edge c.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present one request, record the expected response, and return in its response cycle.
   task automatic issue(input int k, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b);
      exp_t        e;
      bit          bad;
      int          lat;
      int          idx;
      logic [31:0] mask;
      bad = (a[1:0] != 2'b00) || ((a >> 10) != 32'd0);
      lat = bad ? 0 : ws[k];
      req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = wd; be[k] = b;
      e.k = k; e.cyc = cyc + 1 + lat; e.data = 32'd0;
      if (bad) begin
         e.kind = 2;
      end else begin
         idx = int'(a[9:2]);
         if (w) begin
            e.kind = 1;
            mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
            mem_m[k][idx] = (mem_m[k][idx] & ~mask) | (wd & mask);
         end else begin
            e.kind = 0;
            e.data = mem_m[k][idx];
         end
      end
      expq.push_back(e);
      pend_until[k] = e.cyc;
      repeat (lat + 1) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k, input int n);
      req[k] = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rand_run(input int k, input int n_ops);
      logic [31:0] a;
      int          r;
      for (int n = 0; n < n_ops; n++) begin
         r = $urandom_range(0, 7);
         a = 32'($urandom_range(0, 15)) << 2;
         if (r == 6) a = a | 32'($urandom_range(1, 3));
         if (r == 7) a = a | (32'($urandom_range(1, 255)) << 10);
         issue(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
         idle(k, $urandom_range(0, 2));
      end
   endtask

   // Every cycle, compare each out-of-reset instance against the expected responses.
   always @(negedge clk) begin : cmp
      bit          rv, wk, er;
      logic [31:0] d;
      for (int k = 0; k < 3; k++) begin
         if (rst_n[k]) begin
            rv = 1'b0; wk = 1'b0; er = 1'b0; d = 32'd0;
            foreach (expq[i]) begin
               if (expq[i].k == k && expq[i].cyc == cyc) begin
                  if (expq[i].kind == 0) begin rv = 1'b1; d = expq[i].data; end
                  if (expq[i].kind == 1) wk = 1'b1;
                  if (expq[i].kind == 2) er = 1'b1;
               end
            end
            if (rv) last_rd[k] = d;
            if (rvalid[k]) seen_rv_cyc[k] = cyc;
            chk($sformatf("rvalid[%0d]@%0d", k, cyc), 32'(rvalid[k]), 32'(rv));
            chk($sformatf("wack[%0d]@%0d", k, cyc), 32'(wack[k]), 32'(wk));
            chk($sformatf("err[%0d]@%0d", k, cyc), 32'(err[k]), 32'(er));
            chk($sformatf("rdata[%0d]@%0d", k, cyc), rdata[k], last_rd[k]);
            chk($sformatf("busy[%0d]@%0d", k, cyc), 32'(busy[k]),
                32'(req[k] || (cyc < pend_until[k])));
         end
      end
      keep = {};
      foreach (expq[i]) if (expq[i].cyc > cyc) keep.push_back(expq[i]);
      expq = keep;
   end

   // Directed scenarios, then randomized traffic on all three wait-state settings.
   initial begin : stim
      int c0;
      for (int k = 0; k < 3; k++) begin
         rst_n[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0;
         wdata[k] = 32'd0; be[k] = 4'd0; pend_until[k] = 0; seen_rv_cyc[k] = -1;
         last_rd[k] = 32'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset_busy[%0d]", k), 32'(busy[k]), 32'd0);
         chk($sformatf("reset_rvalid[%0d]", k), 32'(rvalid[k]), 32'd0);
         chk($sformatf("reset_wack[%0d]", k), 32'(wack[k]), 32'd0);
         chk($sformatf("reset_err[%0d]", k), 32'(err[k]), 32'd0);
         chk($sformatf("reset_rdata[%0d]", k), rdata[k], 32'd0);
         rst_n[k] = 1'b1;
      end
      @(posedge clk); #1;

      // Give words 0..15 of every instance known contents.
      for (int k = 0; k < 3; k++) begin
         for (int w = 0; w < 16; w++) begin
            issue(k, 1'b1, 32'(w) << 2, $urandom, 4'hF);
         end
         idle(k, 1);
      end

      // Store then load through two wait states.
      issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      @(negedge clk); #1;
      chk("t1_wack", 32'(wack[0]), 32'd1);
      idle(0, 1);
      issue(0, 1'b0, 32'h10, 32'd0, 4'h0);
      @(negedge clk); #1;
      chk("t1_rdata", rdata[0], 32'hDEADBEEF);
      idle(0, 1);

      // Partial byte-enable merge.
      issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
      idle(0, 0);
      issue(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
      idle(0, 1);
      issue(0, 1'b0, 32'h20, 32'd0, 4'h0);
      @(negedge clk); #1;
      chk("t2_rdata", rdata[0], 32'h11BB33DD);
      idle(0, 1);

      // Misaligned and out-of-range requests.
      issue(0, 1'b0, 32'h13, 32'd0, 4'h0);
      @(negedge clk); #1;
      chk("t3_err", 32'(err[0]), 32'd1);
      chk("t3_rdata_held", rdata[0], 32'h11BB33DD);
      idle(0, 1);
      issue(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF);
      idle(0, 1);
      issue(0, 1'b0, 32'h0, 32'd0, 4'h0);
      idle(0, 1);
      issue(0, 1'b1, 32'h0, 32'h00000000, 4'h0);
      idle(0, 1);
      issue(0, 1'b0, 32'h0, 32'd0, 4'h0);
      idle(0, 1);

      // Back-to-back loads with no wait states.
      for (int w = 0; w < 8; w++) issue(1, 1'b0, 32'(w) << 2, 32'd0, 4'h0);
      idle(1, 2);

      // Reset during the first wait cycle of a store.
      issue(0, 1'b1, 32'h8, 32'h12345678, 4'hF);
      idle(0, 1);
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'h55; be[0] = 4'hF;
      @(posedge clk); #1;
      rst_n[0] = 1'b0; req[0] = 1'b0;
      @(posedge clk); #1;
      chk("t5_busy", 32'(busy[0]), 32'd0);
      chk("t5_rvalid", 32'(rvalid[0]), 32'd0);
      chk("t5_wack", 32'(wack[0]), 32'd0);
      chk("t5_err", 32'(err[0]), 32'd0);
      chk("t5_rdata", rdata[0], 32'd0);
      rst_n[0] = 1'b1; last_rd[0] = 32'd0; pend_until[0] = 0;
      repeat (4) @(posedge clk); #1;
      issue(0, 1'b0, 32'h8, 32'd0, 4'h0);
      @(negedge clk); #1;
      chk("t5_old_value", rdata[0], 32'h12345678);
      idle(0, 1);

      // Maximum wait states: response sixteen cycles after the request cycle.
      c0 = cyc;
      issue(2, 1'b0, 32'h10, 32'd0, 4'h0);
      @(negedge clk); #1;
      chk("t6_latency", 32'(seen_rv_cyc[2] - c0), 32'd16);
      idle(2, 1);

      fork
         rand_run(0, 40);
         rand_run(1, 60);
         rand_run(2, 25);
      join
      repeat (3) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
